// File: rtl/cnt_mon_pkg.sv
// cnt_mon_pkg
// Shared definitions for the counter event monitor:
//   CNT_W       - width of the monitored upstream counter
//   WRAP_W_DEF  - default width of the saturating wrap-event counter
//   state_t     - monitor FSM state encodings
package cnt_mon_pkg;

  localparam int CNT_W      = 4;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no valid previous sample yet
    ST_TRACK = 2'd1,  // checking every sample against prev+1
    ST_ERR   = 2'd2   // sequence error seen, held until clr
  } state_t;

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (count -> 0)
//   inc  - increment by one unless already at all-ones
//   clr  - synchronous clear, takes priority over inc
//   cnt  - current count
module sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_evt_mon.sv
// cnt_evt_mon
// Watches the output of an upstream 4-bit loadable up-counter, flags
// out-of-sequence samples, counts 15->0 wraps and pulses when the count
// enters a threshold value.
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst         - asynchronous active-high reset
//   load_in     - copy of the upstream counter's load strobe
//   count_in    - upstream counter value
//   thresh      - value that raises match_pulse when entered
//   clr         - synchronous clear of statistics, error and FSM
//   wrap_cnt    - saturating number of wraps seen
//   wrap_pulse  - one-cycle wrap indication
//   match_pulse - one-cycle threshold-entry indication
//   err         - sticky sequence error
//   state       - FSM state encoding
module cnt_evt_mon
  import cnt_mon_pkg::*;
#(
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_in,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [CNT_W-1:0]  thresh,
  input  logic              clr,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              wrap_pulse,
  output logic              match_pulse,
  output logic              err,
  output logic [1:0]        state
);

  state_t           st;
  logic [CNT_W-1:0] prev_cnt;
  logic             prev_ld;

  logic [CNT_W-1:0] expected;
  logic             active;
  logic             legal;
  logic             wrap_det;
  logic             match_det;

  // Checks only make sense once a previous sample exists.
  assign active   = (st == ST_TRACK) || (st == ST_ERR);
  assign expected = prev_cnt + CNT_W'(1);
  // A load on the previous cycle makes any next value acceptable.
  assign legal    = (count_in == expected) || prev_ld;
  assign wrap_det = active && (prev_cnt == '1) && (count_in == '0) && !prev_ld;
  // Fires on entry into thresh; a reload counts as a fresh entry even when
  // the value does not change.
  assign match_det = active && (count_in == thresh) &&
                     ((prev_cnt != thresh) || prev_ld);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ST_IDLE;
      prev_cnt    <= '0;
      prev_ld     <= 1'b0;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      err         <= 1'b0;
    end else begin
      // History is captured every edge, clr included, so tracking can
      // resume from a real sample after the IDLE edge.
      prev_cnt <= count_in;
      prev_ld  <= load_in;
      if (clr) begin
        st          <= ST_IDLE;
        wrap_pulse  <= 1'b0;
        match_pulse <= 1'b0;
        err         <= 1'b0;
      end else begin
        wrap_pulse  <= wrap_det;
        match_pulse <= match_det;
        case (st)
          ST_IDLE: begin
            st <= ST_TRACK;
          end
          ST_TRACK: begin
            if (!legal) begin
              st  <= ST_ERR;
              err <= 1'b1;
            end
          end
          ST_ERR: begin
            st  <= ST_ERR;
            err <= 1'b1;
          end
          default: begin
            st  <= ST_IDLE;
            err <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_cnt #(
    .WIDTH (WRAP_W)
  ) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap_det),
    .clr (clr),
    .cnt (wrap_cnt)
  );

  assign state = st;

endmodule

// File: doc/cnt_evt_mon.md
CNT_EVT_MON -- requirements
Module: cnt_evt_mon

Interface
REQ-001 The block SHALL have parameter WRAP_W, default 8, width of the wrap-event counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port load_in, input, 1, copy of the load strobe driven to the upstream 4-bit loadable up-counter.
REQ-005 The block SHALL have port count_in, input, 4, the upstream counter's count output.
REQ-006 The block SHALL have port thresh, input, 4, match value for match_pulse.
REQ-007 The block SHALL have port clr, input, 1, synchronous clear of statistics and error.
REQ-008 The block SHALL have port wrap_cnt, output, WRAP_W, saturating count of 15->0 wraps.
REQ-009 The block SHALL have port wrap_pulse, output, 1, one-cycle wrap indication.
REQ-010 The block SHALL have port match_pulse, output, 1, one-cycle threshold-entry indication.
REQ-011 The block SHALL have port err, output, 1, sticky sequence-error flag.
REQ-012 The block SHALL have port state, output, 2, current FSM state encoding.

Function
REQ-013 The block SHALL register count_in into prev_cnt and load_in into prev_ld on every rising edge when not in reset.
REQ-014 The FSM SHALL have states IDLE=0 (no valid prev sample), TRACK=1, ERR=2; encoding 3 unused and SHALL recover to IDLE.
REQ-015 IDLE SHALL go to TRACK after one rising edge, with no checks and no pulses on that edge.
REQ-016 In TRACK, expected value = prev_cnt+1 modulo 16; a sample is legal if count_in equals expected or prev_ld=1.
REQ-017 In TRACK, an illegal sample SHALL set err=1 and move to ERR on the same edge.
REQ-018 A wrap SHALL be declared when prev_cnt=15, count_in=0 and prev_ld=0, in TRACK or ERR.
REQ-019 On a wrap, wrap_pulse SHALL be 1 for exactly the following cycle, and wrap_cnt SHALL increment, saturating at 2^WRAP_W-1.
REQ-020 match_pulse SHALL be 1 for the cycle after an edge where count_in=thresh and (prev_cnt!=thresh or prev_ld=1), in TRACK or ERR only.
REQ-021 ERR SHALL be held until clr; err SHALL stay 1 throughout ERR.
REQ-022 clr=1 at an edge SHALL force wrap_cnt=0, err=0, wrap_pulse=0, match_pulse=0 and state=IDLE; clr SHALL override a simultaneous wrap, match or error.
REQ-023 All outputs SHALL be registered; decision latency from count_in sample to output is one clock.
REQ-024 A change of thresh SHALL take effect on the next edge, with no retroactive pulse.

Reset
REQ-025 rst=1 SHALL immediately set state=IDLE, wrap_cnt=0, wrap_pulse=0, match_pulse=0, err=0, prev_cnt=0, prev_ld=0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard all history; after release the first edge SHALL behave as REQ-015.

Structure
REQ-027 A shared package cnt_mon_pkg SHALL hold the state encodings, the WRAP_W default and the 4-bit count width constant.
REQ-028 The saturating wrap counter SHALL be a single sub-module sat_cnt (parameter width; inputs inc, clr).
REQ-029 The design SHALL contain no latches, one clock domain, and be 120-400 lines total.

Verification
REQ-030 Bench: reset, load 12, free-run 12,13,14,15,0,1 -> wrap_pulse high exactly one cycle after the 0 sample, wrap_cnt=1, err=0.
REQ-031 Bench: thresh=14, count runs 12..15 -> match_pulse high one cycle after the 14 sample; hold count at 14 with load 14 repeated -> match_pulse re-fires each loaded cycle.
REQ-032 Bench: count 5 then 7 with load_in=0 -> err=1, state=2 next cycle; apply clr -> err=0, state=0.
REQ-033 Bench: load_in=1 at count 3, next sample 9 -> no error, state stays 1.
REQ-034 Bench: WRAP_W=4, 20 wraps -> wrap_cnt saturates at 15, wrap_pulse still fires each wrap.
REQ-035 Bench: clr asserted on the same edge as a 15->0 wrap -> wrap_cnt=0, wrap_pulse=0; async rst mid-run -> all outputs 0 before the next edge.
